boreal_cursor_ctrl_top: RTL and testbench

- Top-level EEG-to-cursor controller.
- Takes 8-channel time-multiplexed ADC samples, integrates per-channel signal energy into signed X/Y control values, applies deadzone, gain, safety-tier scaling and smoothing, then emits cursor packets over a UART on request.
- Includes a saturation guard and an emergency halt that force zero motion.

---
 rtl/boreal_cursor_ctrl_top.sv | 242 ++++++++++++++++++++++++
 tb/tb_boreal_cursor_ctrl_top.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/boreal_cursor_ctrl_top.sv
// rtl/boreal_cursor_ctrl_top.sv - EEG channel energy to cursor motion, emitted as UART packets
// Define BOREAL_CLICK_EN to enable the channel-4 left-click button.
module boreal_cursor_ctrl_top #(
  parameter int SAT_LIMIT    = 30000,
  parameter int FREEZE_HOLD  = 1024,
  parameter int LEAK_SHIFT   = 8,
  parameter int DEAD         = 200,
  parameter int GAIN_SHIFT   = 4,
  parameter int CLKS_PER_BIT = 868,
  parameter int CLICK_TH     = 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        emergency_halt_n,
  input  logic [23:0] raw_adc_in,
  input  logic [2:0]  adc_channel_sel,
  input  logic        adc_data_ready,
  input  logic [1:0]  safety_tier,
  input  logic        send_packet_strobe,
  output logic        uart_tx
);

`ifdef BOREAL_CLICK_EN
  localparam int NCH = 5;
`else
  localparam int NCH = 4;
`endif
  localparam logic [15:0]        SAT_L    = 16'(SAT_LIMIT);
  localparam logic [15:0]        HOLD_L   = 16'(FREEZE_HOLD);
  localparam logic signed [16:0] DEAD_L   = 17'(DEAD);
  localparam int                 CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic signed [15:0] s;
  logic [15:0]        mag;
  logic               sat, frame_end, sample_d;
  logic               noise_freeze, left_state;
  logic [15:0]        hold_cnt;
  logic [31:0]        acc [NCH];
  logic [31:0]        e [NCH];
  logic signed [15:0] mu_x, mu_y;
  logic signed [7:0]  dx_m, dy_m, dx_g, dy_g, dx, dy;
  logic               unused_low;

  assign s          = raw_adc_in[23:8];
  assign unused_low = ^raw_adc_in[7:0];
  assign sat        = mag >= SAT_L;
  assign frame_end  = adc_data_ready && (adc_channel_sel == 3'd7);

  // -32768 has no positive twin in 16 bits, so it folds onto 32767
  always_comb begin
    if (!s[15])               mag = s;
    else if (s == 16'sh8000)  mag = 16'h7fff;
    else                      mag = -s;
  end

  function automatic logic signed [15:0] sat16(input logic [31:0] a, input logic [31:0] b);
    logic signed [32:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d > 33'sd32767)       return 16'sh7fff;
    else if (d < -33'sd32768) return 16'sh8000;
    else                      return d[15:0];
  endfunction

  function automatic logic signed [7:0] motor(input logic signed [15:0] mu);
    logic signed [16:0] t;
    t = $signed({mu[15], mu});
    if (t > -DEAD_L && t < DEAD_L) return 8'sd0;
    t = mu[15] ? (t + DEAD_L) : (t - DEAD_L);
    t = t >>> GAIN_SHIFT;
    if (t > 17'sd127)  return 8'sd127;
    if (t < -17'sd127) return -8'sd127;
    return t[7:0];
  endfunction

  // First-order smoother step, widened so the difference cannot wrap
  function automatic logic signed [7:0] smooth(input logic signed [7:0] cur, input logic signed [7:0] tgt);
    logic signed [9:0] diff;
    diff = {{2{tgt[7]}}, tgt} - {{2{cur[7]}}, cur};
    return cur + 8'(diff >>> 2);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noise_freeze <= 1'b0;
      hold_cnt     <= '0;
    end else if (adc_data_ready) begin
      if (sat) begin
        noise_freeze <= 1'b1;
        hold_cnt     <= '0;
      end else if (noise_freeze) begin
        if (hold_cnt + 16'd1 >= HOLD_L) begin
          noise_freeze <= 1'b0;
          hold_cnt     <= '0;
        end else begin
          hold_cnt <= hold_cnt + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || !emergency_halt_n) begin
      for (int i = 0; i < NCH; i++) acc[i] <= '0;
    end else if (adc_data_ready) begin
      for (int i = 0; i < NCH; i++)
        if (adc_channel_sel == 3'(i))
          acc[i] <= acc[i] - (acc[i] >> LEAK_SHIFT) + {16'd0, mag};
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) e[i] = acc[i] >> LEAK_SHIFT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_d <= 1'b0;
      mu_x     <= '0;
      mu_y     <= '0;
    end else begin
      sample_d <= adc_data_ready;
      if (!emergency_halt_n) begin
        mu_x <= '0;
        mu_y <= '0;
      end else if (sample_d) begin
        mu_x <= sat16(e[0], e[1]);
        mu_y <= sat16(e[2], e[3]);
      end
    end
  end

  assign dx_m = motor(mu_x);
  assign dy_m = motor(mu_y);

  always_comb begin
    dx_g = '0;
    dy_g = '0;
    case (safety_tier)
      2'd0: begin dx_g = dx_m;       dy_g = dy_m;       end
      2'd1: begin dx_g = dx_m >>> 1; dy_g = dy_m >>> 1; end
      2'd2: begin dx_g = dx_m >>> 2; dy_g = dy_m >>> 2; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx <= '0;
      dy <= '0;
    end else if (frame_end) begin
      if (noise_freeze || !emergency_halt_n) begin
        dx <= '0;
        dy <= '0;
      end else begin
        dx <= smooth(dx, dx_g);
        dy <= smooth(dy, dy_g);
      end
    end
  end

`ifdef BOREAL_CLICK_EN
  localparam logic [31:0] CLICK_L = 32'(CLICK_TH);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) left_state <= 1'b0;
    else     left_state <= (e[4] > CLICK_L) && !noise_freeze;
  end
`else
  logic unused_click;
  assign unused_click = (CLICK_TH == 0);
  assign left_state   = 1'b0;
`endif

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  tx_state_t     state, state_n;
  logic [39:0]   pkt, pkt_n;
  logic [2:0]    byte_idx, byte_n;
  logic [3:0]    bit_idx, bit_n;
  logic [CW-1:0] clk_cnt, cnt_n;
  logic [7:0]    buttons, chk, cur_byte;

  assign buttons  = {7'b0, left_state};
  assign chk      = 8'hA5 ^ dx ^ dy ^ buttons;
  assign cur_byte = pkt[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      pkt      <= '0;
      byte_idx <= '0;
      bit_idx  <= '0;
      clk_cnt  <= '0;
    end else begin
      state    <= state_n;
      pkt      <= pkt_n;
      byte_idx <= byte_n;
      bit_idx  <= bit_n;
      clk_cnt  <= cnt_n;
    end
  end

  // Bytes go out lowest first; pkt shifts down one byte after each stop bit
  always_comb begin
    state_n = state;
    pkt_n   = pkt;
    byte_n  = byte_idx;
    bit_n   = bit_idx;
    cnt_n   = clk_cnt;
    uart_tx = 1'b1;
    case (state)
      TX_IDLE: begin
        if (send_packet_strobe) begin
          state_n = TX_SEND;
          pkt_n   = {chk, buttons, dy, dx, 8'hA5};
          byte_n  = '0;
          bit_n   = '0;
          cnt_n   = '0;
        end
      end
      TX_SEND: begin
        if (bit_idx == 4'd0)      uart_tx = 1'b0;
        else if (bit_idx == 4'd9) uart_tx = 1'b1;
        else                      uart_tx = cur_byte[3'(bit_idx - 4'd1)];
        if (clk_cnt == CNT_LAST) begin
          cnt_n = '0;
          if (bit_idx == 4'd9) begin
            bit_n = '0;
            pkt_n = {8'h00, pkt[39:8]};
            if (byte_idx == 3'd4) state_n = TX_IDLE;
            else                  byte_n  = byte_idx + 3'd1;
          end else begin
            bit_n = bit_idx + 4'd1;
          end
        end else begin
          cnt_n = clk_cnt + CW'(1);
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_boreal_cursor_ctrl_top.sv
// tb/tb_boreal_cursor_ctrl_top.sv - directed vector bench for boreal_cursor_ctrl_top
// LEAK_SHIFT=2 makes settled channel energy equal |sample|; CLKS_PER_BIT=16 keeps packets short.
module tb_boreal_cursor_ctrl_top;
  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        emergency_halt_n = 1'b1;
  logic [23:0] raw_adc_in = '0;
  logic [2:0]  adc_channel_sel = '0;
  logic        adc_data_ready = 1'b0;
  logic [1:0]  safety_tier = '0;
  logic        send_packet_strobe = 1'b0;
  logic        uart_tx;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int s0, s1, s2, s3, tier;
    int mu_x, mu_y, dx_g, dx, dy;
  } vec_t;
  vec_t vt [8];

  always #5 clk = ~clk;

  boreal_cursor_ctrl_top #(
    .SAT_LIMIT(30000), .FREEZE_HOLD(1024), .LEAK_SHIFT(2), .DEAD(200),
    .GAIN_SHIFT(4), .CLKS_PER_BIT(CPB), .CLICK_TH(4000)
  ) dut (
    .clk(clk), .rst(rst), .emergency_halt_n(emergency_halt_n),
    .raw_adc_in(raw_adc_in), .adc_channel_sel(adc_channel_sel),
    .adc_data_ready(adc_data_ready), .safety_tier(safety_tier),
    .send_packet_strobe(send_packet_strobe), .uart_tx(uart_tx)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic put(input int ch, input int val);
    @(negedge clk);
    raw_adc_in      = {val[15:0], 8'h5A};
    adc_channel_sel = ch[2:0];
    adc_data_ready  = 1'b1;
    @(negedge clk);
    adc_data_ready  = 1'b0;
  endtask

  task automatic frame(input int s0, input int s1, input int s2, input int s3, input int s5);
    put(0, s0); put(1, s1); put(2, s2); put(3, s3);
    put(4, 0);  put(5, s5); put(6, 0);  put(7, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    emergency_halt_n = 1'b1;
    send_packet_strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Freeze first so the accumulators settle while dx is pinned to 0,
  // then dx tracks a constant target from 0 deterministically.
  task automatic run_vec(input int i);
    do_reset();
    safety_tier = 2'(vt[i].tier);
    frame(vt[i].s0, vt[i].s1, vt[i].s2, vt[i].s3, 32767);
    check($sformatf("v%0d_freeze_on", i), int'(dut.noise_freeze), 1);
    for (int f = 1; f < 170; f++) begin
      frame(vt[i].s0, vt[i].s1, vt[i].s2, vt[i].s3, 0);
      if (f == 127) begin
        check($sformatf("v%0d_freeze_hold", i), int'(dut.noise_freeze), 1);
        check($sformatf("v%0d_dx_frozen", i), int'(dut.dx), 0);
      end
      if (f == 128) check($sformatf("v%0d_freeze_release", i), int'(dut.noise_freeze), 0);
    end
    repeat (3) @(negedge clk);
    check($sformatf("v%0d_mu_x", i), int'(dut.mu_x), vt[i].mu_x);
    check($sformatf("v%0d_mu_y", i), int'(dut.mu_y), vt[i].mu_y);
    check($sformatf("v%0d_dx_g", i), int'(dut.dx_g), vt[i].dx_g);
    check($sformatf("v%0d_dx", i),   int'(dut.dx),   vt[i].dx);
    check($sformatf("v%0d_dy", i),   int'(dut.dy),   vt[i].dy);
  endtask

  task automatic uart_pkt(input string tag, input logic [39:0] exp, input bit mid_strobe);
    logic [7:0] b;
    logic       st, sp;
    int         skip;
    skip = 0;
    b = '0; st = 1'b1; sp = 1'b0;
    @(negedge clk); send_packet_strobe = 1'b1;
    @(negedge clk); send_packet_strobe = 1'b0;
    for (int by = 0; by < 5; by++) begin
      for (int bt = 0; bt < 10; bt++) begin
        if (by == 0 && bt == 0) repeat (CPB/2) @(negedge clk);
        else repeat (CPB - skip) @(negedge clk);
        skip = 0;
        if (bt == 0)      st = uart_tx;
        else if (bt == 9) sp = uart_tx;
        else              b[bt-1] = uart_tx;
        if (mid_strobe && by == 2 && bt == 3) begin
          @(negedge clk); send_packet_strobe = 1'b1;
          @(negedge clk); send_packet_strobe = 1'b0;
          skip = 2;
        end
      end
      check($sformatf("%s_b%0d_framing", tag, by), int'({st, sp}), 1);
      check($sformatf("%s_b%0d_data", tag, by), int'(b), int'(exp[by*8 +: 8]));
    end
    for (int k = 0; k < 2; k++) begin
      repeat (CPB) @(negedge clk);
      check($sformatf("%s_idle%0d", tag, k), int'(uart_tx), 1);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    vt[0] = '{2000,     0,    0,    0, 0,  2000,     0, 112, 109,   0};
    vt[1] = '{   0, -3000, 5000, 1000, 1, -3000,  4000, -64, -64,  60};
    vt[2] = '{5000,  1000,    0, 2600, 2,  4000, -2600,  31,  28, -32};
    vt[3] = '{8000,     0,    0,    0, 3,  8000,     0,   0,   0,   0};
    vt[4] = '{ 199,     0,    0,  217, 0,   199,  -217,   0,   0,  -2};
    vt[5] = '{29999,    0,    0,    0, 0, 29999,     0, 127, 124,   0};
    vt[6] = '{ 336,     0,    0,    0, 0,   336,     0,   8,   5,   0};
    vt[7] = '{ 100,     0,    0,    0, 0,   100,     0,   0,   0,   0};

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", int'(uart_tx), 1);
    check("rst_mu_x", int'(dut.mu_x), 0);
    check("rst_mu_y", int'(dut.mu_y), 0);
    check("rst_dx", int'(dut.dx), 0);
    check("rst_freeze", int'(dut.noise_freeze), 0);
    check("rst_left", int'(dut.left_state), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_uart_tx", int'(uart_tx), 1);
    check("post_rst_dx_m", int'(dut.dx_m), 0);

    for (int i = 0; i < 8; i++) run_vec(i);

    // Saturating sample after integration
    run_vec(5);
    put(0, 32767);
    check("sat_freeze_fast", int'(dut.noise_freeze), 1);
    check("sat_dx_before_end", int'(dut.dx), 124);
    put(1, 0); put(2, 0); put(3, 0); put(4, 0); put(5, 0); put(6, 0); put(7, 0);
    check("sat_dx_zero", int'(dut.dx), 0);

    // Emergency halt and recovery
    run_vec(0);
    emergency_halt_n = 1'b0;
    @(negedge clk);
    check("halt_mu_x", int'(dut.mu_x), 0);
    frame(2000, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("halt_mu_x_frame", int'(dut.mu_x), 0);
    check("halt_dx", int'(dut.dx), 0);
    emergency_halt_n = 1'b1;
    frame(2000, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("resume_mu_x", int'(dut.mu_x), 500);
    check("resume_dx", int'(dut.dx), 4);

    // UART packets
    run_vec(6);
    uart_pkt("pkt1", 40'hA0_00_00_05_A5, 1'b1);
    run_vec(1);
    uart_pkt("pkt2", 40'h59_00_3C_C0_A5, 1'b0);

    // Reset in the middle of a start bit
    @(negedge clk); send_packet_strobe = 1'b1;
    @(negedge clk); send_packet_strobe = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_start_bit", int'(uart_tx), 0);
    #2 rst = 1'b1;
    #1 check("abort_tx_high", int'(uart_tx), 1);
    @(negedge clk); rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_idle", int'(uart_tx), 1);
    check("abort_dx", int'(dut.dx), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
